// File: rtl/osc_draw_scheduler.sv
// osc_draw_scheduler
// Shares one X/Y DAC pair between the ball, the paddle and the score bar.
// Once per frame the game state is copied into shadow registers. The
// scheduler then steps through each object point by point. Every point is
// held for DWELL cycles. The first point of each object gets SETTLE extra
// blanked cycles so the beam can move to the new object before it is shown.
module osc_draw_scheduler #(
    parameter int X_MAX          = 255,
    parameter int Y_MAX          = 220,
    parameter int PLATE_HALFWIDTH = 15,
    parameter int PLATE_X        = 255,
    parameter int BALL_R         = 1,
    parameter int DWELL          = 4,
    parameter int SETTLE         = 16,
    parameter int SCORE_Y        = 235,
    parameter int SCORE_STEP     = 4,
    parameter int SCORE_MAX_DOTS = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x_b,
    input  logic [7:0] y_b,
    input  logic [7:0] y_p_mid,
    input  logic [7:0] score,
    output logic [7:0] dac_x,
    output logic [7:0] dac_y,
    output logic       dac_we,
    output logic       blank,
    output logic       frame_start,
    output logic [1:0] obj
);

    localparam int BW = $clog2(2*BALL_R + 2);
    localparam int HW = $clog2(SETTLE + DWELL + 1);

    localparam logic [BW-1:0]     BMAX       = BW'(2*BALL_R);
    localparam logic [HW-1:0]     FIRST_HOLD = HW'(SETTLE + DWELL - 1);
    localparam logic [HW-1:0]     NEXT_HOLD  = HW'(DWELL - 1);
    localparam logic [HW-1:0]     DWELL_H    = HW'(DWELL);
    localparam logic [7:0]        X_MAX_C    = 8'(X_MAX);
    localparam logic [7:0]        Y_MAX_C    = 8'(Y_MAX);
    localparam logic [7:0]        PH_C       = 8'(PLATE_HALFWIDTH);
    localparam logic [7:0]        PAD_HI_LIM = 8'(Y_MAX - PLATE_HALFWIDTH);
    localparam logic [7:0]        PLATE_X_C  = 8'(PLATE_X);
    localparam logic [7:0]        SCORE_Y_C  = 8'(SCORE_Y);
    localparam logic [7:0]        STEP_C     = 8'(SCORE_STEP);
    localparam logic [7:0]        SMAX_C     = 8'(SCORE_MAX_DOTS);
    localparam logic signed [10:0] R_S       = 11'(BALL_R);

    // Encoding chosen so the state value is directly the obj code.
    typedef enum logic [1:0] {
        ST_BALL   = 2'd0,
        ST_PADDLE = 2'd1,
        ST_SCORE  = 2'd2,
        ST_LATCH  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          started_reg, started_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          first_reg, first_next;
    logic [7:0]    idx_reg, idx_next;
    logic [BW-1:0] dx_reg, dx_next, dy_reg, dy_next;
    logic [7:0]    xb_sh_reg, yb_sh_reg, yp_sh_reg, sc_sh_reg;
    logic          latch_en, new_pt, blank_next;
    logic [7:0]    pt_x, pt_y;
    logic [7:0]    pad_min, pad_max, pad_span, sc_n;

    // Ball axis coordinate: base + k - BALL_R, clamped to [0, lim]. The
    // extra headroom bits keep 255+1 from wrapping to a negative value.
    function automatic logic [7:0] ball_axis(input logic [7:0]    base,
                                             input logic [BW-1:0] k,
                                             input logic [7:0]    lim);
        logic signed [10:0] s;
        s = $signed({3'b000, base}) + $signed(11'(k)) - R_S;
        if (s < 11'sd0)
            return 8'd0;
        else if (s > $signed({3'b000, lim}))
            return lim;
        else
            return s[7:0];
    endfunction

    // Paddle extent and score dot count, derived from the shadow copies
    always_comb begin
        pad_max  = (yp_sh_reg <= PAD_HI_LIM) ? yp_sh_reg + PH_C : Y_MAX_C;
        pad_min  = (yp_sh_reg >= PH_C) ? yp_sh_reg - PH_C : 8'd0;
        pad_span = pad_max - pad_min;
        sc_n     = (sc_sh_reg > SMAX_C) ? SMAX_C : sc_sh_reg;
    end

    // Next-state, point sequencing and next output values
    always_comb begin
        state_next   = state_reg;
        started_next = started_reg;
        hold_next    = hold_reg;
        first_next   = first_reg;
        idx_next     = idx_reg;
        dx_next      = dx_reg;
        dy_next      = dy_reg;
        latch_en     = 1'b0;
        new_pt       = 1'b0;
        pt_x         = dac_x;
        pt_y         = dac_y;
        if (state_reg == ST_LATCH) begin
            if (!started_reg) begin
                // The first cycle after reset is a visible LATCH cycle.
                started_next = 1'b1;
            end else begin
                latch_en   = 1'b1;
                state_next = ST_BALL;
                dx_next    = '0;
                dy_next    = '0;
                first_next = 1'b1;
                hold_next  = FIRST_HOLD;
                new_pt     = 1'b1;
                pt_x       = ball_axis(x_b, '0, X_MAX_C);
                pt_y       = ball_axis(y_b, '0, Y_MAX_C);
            end
        end else if (hold_reg != '0) begin
            hold_next = hold_reg - HW'(1);
        end else begin
            first_next = 1'b0;
            hold_next  = NEXT_HOLD;
            new_pt     = 1'b1;
            case (state_reg)
                ST_BALL: begin
                    if (dx_reg == BMAX && dy_reg == BMAX) begin
                        state_next = ST_PADDLE;
                        idx_next   = 8'd0;
                        first_next = 1'b1;
                        hold_next  = FIRST_HOLD;
                        pt_x       = PLATE_X_C;
                        pt_y       = pad_min;
                    end else begin
                        if (dx_reg == BMAX) begin
                            dx_next = '0;
                            dy_next = dy_reg + BW'(1);
                        end else begin
                            dx_next = dx_reg + BW'(1);
                        end
                        pt_x = ball_axis(xb_sh_reg, dx_next, X_MAX_C);
                        pt_y = ball_axis(yb_sh_reg, dy_next, Y_MAX_C);
                    end
                end
                ST_PADDLE: begin
                    if (idx_reg == pad_span) begin
                        if (sc_n == 8'd0) begin
                            state_next = ST_LATCH;
                            new_pt     = 1'b0;
                            hold_next  = '0;
                        end else begin
                            state_next = ST_SCORE;
                            idx_next   = 8'd0;
                            first_next = 1'b1;
                            hold_next  = FIRST_HOLD;
                            pt_x       = 8'd0;
                            pt_y       = SCORE_Y_C;
                        end
                    end else begin
                        idx_next = idx_reg + 8'd1;
                        pt_x     = PLATE_X_C;
                        pt_y     = pad_min + idx_next;
                    end
                end
                default: begin
                    if (idx_reg == sc_n - 8'd1) begin
                        state_next = ST_LATCH;
                        new_pt     = 1'b0;
                        hold_next  = '0;
                    end else begin
                        idx_next = idx_reg + 8'd1;
                        pt_x     = idx_next * STEP_C;
                        pt_y     = SCORE_Y_C;
                    end
                end
            endcase
        end
        blank_next = (state_next == ST_LATCH) ||
                     (first_next && (hold_next >= DWELL_H));
    end

    // State, counters, shadow registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_LATCH;
            started_reg <= 1'b0;
            hold_reg    <= '0;
            first_reg   <= 1'b0;
            idx_reg     <= 8'd0;
            dx_reg      <= '0;
            dy_reg      <= '0;
            xb_sh_reg   <= 8'd0;
            yb_sh_reg   <= 8'd0;
            yp_sh_reg   <= 8'd0;
            sc_sh_reg   <= 8'd0;
            dac_x       <= 8'd0;
            dac_y       <= 8'd0;
            dac_we      <= 1'b0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            obj         <= 2'd3;
        end else begin
            state_reg   <= state_next;
            started_reg <= started_next;
            hold_reg    <= hold_next;
            first_reg   <= first_next;
            idx_reg     <= idx_next;
            dx_reg      <= dx_next;
            dy_reg      <= dy_next;
            if (latch_en) begin
                xb_sh_reg <= x_b;
                yb_sh_reg <= y_b;
                yp_sh_reg <= y_p_mid;
                sc_sh_reg <= score;
            end
            dac_x       <= pt_x;
            dac_y       <= pt_y;
            dac_we      <= new_pt;
            blank       <= blank_next;
            frame_start <= (state_next == ST_LATCH);
            obj         <= state_next;
        end
    end

endmodule

// File: tb/tb_osc_draw_scheduler.sv
// Testbench for osc_draw_scheduler: directed frame vectors with
// hand-computed expectations, plus latency, mid-frame input change and
// asynchronous reset sequences.
module tb_osc_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] x_b, y_b, y_p_mid, score;
    logic [7:0] dac_x, dac_y;
    logic       dac_we, blank, frame_start;
    logic [1:0] obj;

    int n_cmp = 0;
    int n_bad = 0;

    osc_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .x_b        (x_b),
        .y_b        (y_b),
        .y_p_mid    (y_p_mid),
        .score      (score),
        .dac_x      (dac_x),
        .dac_y      (dac_y),
        .dac_we     (dac_we),
        .blank      (blank),
        .frame_start(frame_start),
        .obj        (obj)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, ypm, sc;
        int len;
        int bfx, bfy, blx, bly;
        int np, pfy, ply;
        int ns, slx;
    } vec_t;

    typedef struct {
        int len, nblank;
        int nb, bfx, bfy, blx, bly, bover;
        int np, pfy, ply, pbad;
        int ns, slx, sbad;
    } frame_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Capture one frame; called at the negedge of a LATCH cycle and returns
    // at the negedge of the next LATCH cycle.
    task automatic capture(input int change_at, input logic [7:0] new_ypm,
                           output frame_t f);
        f = '{default: 0};
        f.len = -1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == change_at) y_p_mid = new_ypm;
            if (frame_start) begin
                f.len = cyc;
                break;
            end
            if (blank && obj != 2'd3) f.nblank++;
            if (dac_we) begin
                case (obj)
                    2'd0: begin
                        if (f.nb == 0) begin f.bfx = dac_x; f.bfy = dac_y; end
                        f.blx = dac_x; f.bly = dac_y; f.nb++;
                        if (dac_y > 8'd220) f.bover++;
                    end
                    2'd1: begin
                        if (f.np == 0) f.pfy = dac_y;
                        f.ply = dac_y; f.np++;
                        if (dac_x != 8'd255) f.pbad++;
                    end
                    2'd2: begin
                        f.slx = dac_x; f.ns++;
                        if (dac_y != 8'd235) f.sbad++;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_frame(input string tag, input vec_t v, input frame_t f);
        chk({tag, ".len"},    f.len, v.len);
        chk({tag, ".nball"},  f.nb,  9);
        chk({tag, ".bfx"},    f.bfx, v.bfx);
        chk({tag, ".bfy"},    f.bfy, v.bfy);
        chk({tag, ".blx"},    f.blx, v.blx);
        chk({tag, ".bly"},    f.bly, v.bly);
        chk({tag, ".bover"},  f.bover, 0);
        chk({tag, ".npad"},   f.np,  v.np);
        chk({tag, ".pfy"},    f.pfy, v.pfy);
        chk({tag, ".ply"},    f.ply, v.ply);
        chk({tag, ".padx"},   f.pbad, 0);
        chk({tag, ".nscore"}, f.ns,  v.ns);
        if (v.ns > 0) begin
            chk({tag, ".slx"},  f.slx, v.slx);
            chk({tag, ".sy"},   f.sbad, 0);
        end
        chk({tag, ".nblank"}, f.nblank, 16 * ((v.ns > 0) ? 3 : 2));
        $display("frame %s: len=%0d ball=%0d pad=%0d(%0d..%0d) score=%0d",
                 tag, f.len, f.nb, f.np, f.pfy, f.ply, f.ns);
    endtask

    vec_t   vecs[7];
    frame_t fr;
    vec_t   ev;
    bit     found;

    initial begin
        //            x    y    ypm  sc   len  bfx  bfy  blx  bly  np  pfy  ply  ns  slx
        vecs[0] = '{127, 110, 100,   0, 193, 126, 109, 128, 111, 31,  85, 115,  0,   0};
        vecs[1] = '{  0, 220,   5,   0, 153,   0, 219,   1, 220, 21,   0,  20,  0,   0};
        vecs[2] = '{ 50,  50, 215,   0, 153,  49,  49,  51,  51, 21, 200, 220,  0,   0};
        vecs[3] = '{ 10,  10, 100,   3, 221,   9,   9,  11,  11, 31,  85, 115,  3,   8};
        vecs[4] = '{100, 100, 100, 200, 461,  99,  99, 101, 101, 31,  85, 115, 63, 248};
        vecs[5] = '{255,   0,  14,   1, 209, 254,   0, 255,   1, 30,   0,  29,  1,   0};
        vecs[6] = '{  0,   0, 205,   0, 193,   0,   0,   1,   1, 31, 190, 220,  0,   0};

        reset = 1'b1;
        x_b = 8'd127; y_b = 8'd110; y_p_mid = 8'd100; score = 8'd0;
        #1;
        chk("rst.dac_x", dac_x, 0);
        chk("rst.dac_y", dac_y, 0);
        chk("rst.dac_we", dac_we, 0);
        chk("rst.blank", blank, 1);
        chk("rst.frame_start", frame_start, 0);
        chk("rst.obj", obj, 3);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First edge after release is the LATCH cycle, next is the first ball point
        @(posedge clk); #1;
        chk("lat.frame_start", frame_start, 1);
        chk("lat.obj", obj, 3);
        chk("lat.blank", blank, 1);
        chk("lat.dac_we", dac_we, 0);
        @(posedge clk); #1;
        chk("p0.frame_start", frame_start, 0);
        chk("p0.obj", obj, 0);
        chk("p0.dac_we", dac_we, 1);
        chk("p0.blank", blank, 1);
        chk("p0.dac_x", dac_x, 126);
        chk("p0.dac_y", dac_y, 109);

        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        chk("sync.frame_start", found, 1);

        for (int i = 0; i < 7; i++) begin
            x_b = 8'(vecs[i].x); y_b = 8'(vecs[i].y);
            y_p_mid = 8'(vecs[i].ypm); score = 8'(vecs[i].sc);
            capture(0, 8'd0, fr);
            check_frame($sformatf("v%0d", i), vecs[i], fr);
        end

        // y_p_mid changes during BALL: current frame keeps the latched value
        x_b = 8'd127; y_b = 8'd110; y_p_mid = 8'd100; score = 8'd0;
        capture(10, 8'd50, fr);
        check_frame("mid_a", vecs[0], fr);
        ev = vecs[0]; ev.pfy = 35; ev.ply = 65;
        capture(0, 8'd0, fr);
        check_frame("mid_b", ev, fr);

        // Asynchronous reset in the middle of PADDLE
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (obj == 2'd1) found = 1'b1;
        end
        chk("ar.reach_paddle", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar.dac_x", dac_x, 0);
        chk("ar.dac_y", dac_y, 0);
        chk("ar.dac_we", dac_we, 0);
        chk("ar.blank", blank, 1);
        chk("ar.frame_start", frame_start, 0);
        chk("ar.obj", obj, 3);
        $display("async reset during paddle: dac=(%0d,%0d) obj=%0d", dac_x, dac_y, obj);
        x_b = 8'd40; y_b = 8'd40; y_p_mid = 8'd100; score = 8'd0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ar.lat_frame_start", frame_start, 1);
        chk("ar.lat_obj", obj, 3);
        @(negedge clk);
        ev = vecs[0]; ev.bfx = 39; ev.bfy = 39; ev.blx = 41; ev.bly = 41;
        capture(0, 8'd0, fr);
        check_frame("post_rst", ev, fr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
